exibidor_sequencia: RTL and testbench
=====================================

Name: exibidor_sequencia

Overview:
Playback engine for the memory game: reads stored color codes from the sequence memory, from address 0 up to the current round limit. Shows each code on the RGB LED for a fixed lit time, then a dark gap. Signals completion to the control unit. Sits in the data path between the sequence memory and leds_rgb, started and monitored by the control unit.

Parameters:
TEMPO_ACESO, 2000, clock cycles each color stays lit (>=1)
TEMPO_APAGADO, 500, clock cycles of dark gap after each color (>=1)
ADDR_W, 4, memory address width / limit width
CNT_W, 12, width of the internal timing counter (must hold max(TEMPO_ACESO, TEMPO_APAGADO)-1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
iniciar  input  1  start pulse; sampled only in OCIOSO
limite  input  ADDR_W  last address to show (inclusive); sampled at start
mem_dado  input  4  one-hot color code read from memory at mem_endereco (combinational read)
mem_endereco  output  ADDR_W  address driven to sequence memory
leds_rgb  output  3  registered RGB drive
ocupado  output  1  high from the cycle after start until fim_sequencia
fim_sequencia  output  1  one-cycle pulse when the last gap ends
db_estado  output  4  current state encoding for 7-seg debug

Behaviour:
- Reset (reset=0, async): state OCIOSO; mem_endereco=0, leds_rgb=000, ocupado=0, fim_sequencia=0, timer=0, latched limite=0.
- States and encodings: OCIOSO=0, CARREGA=1, ACENDE=2, APAGA=3, PROXIMO=4, FIM=5. Remaining encodings are illegal and go to OCIOSO.
- OCIOSO: when iniciar=1, latch limite, set mem_endereco=0, and go to CARREGA. Otherwise stay; leds_rgb=000.
- CARREGA (1 cycle): register the decoded mem_dado into leds_rgb, clear the timer, go to ACENDE.
- Decode: 0001->100 (red), 0010->010 (green), 0100->001 (blue), 1000->110 (yellow). Any other value, including 0000 or multi-hot, ->111.
- ACENDE: hold leds_rgb and increment the timer. When timer==TEMPO_ACESO-1, clear leds_rgb to 000 and the timer, then go to APAGA. The LED is therefore lit for exactly TEMPO_ACESO cycles.
- APAGA: leds_rgb=000 and the timer increments. When timer==TEMPO_APAGADO-1, go to PROXIMO.
- PROXIMO (1 cycle): if mem_endereco==latched limite, go to FIM. Otherwise increment mem_endereco and go to CARREGA.
- FIM (1 cycle): fim_sequencia=1, ocupado=0 next, mem_endereco=0, then go to OCIOSO.
- Per element: 1 (CARREGA) + TEMPO_ACESO + TEMPO_APAGADO cycles, plus 1 PROXIMO cycle.
- Total from the iniciar edge to fim_sequencia high: (limite+1)·(TEMPO_ACESO+TEMPO_APAGADO+2)+1 cycles.
- Edge cases:
  - iniciar while not OCIOSO: ignored.
  - limite changes mid-playback: ignored, because the latched copy is used.
  - limite = max (2^ADDR_W−1): all addresses are shown; no wrap occurs because the compare precedes the increment.
  - limite=0: exactly one element.
  - Async reset mid-playback: immediate return to reset values, with no fim_sequencia pulse.
  - iniciar held high continuously: a new playback starts on the cycle after FIM returns to OCIOSO.
- ocupado=1 in CARREGA, ACENDE, APAGA and PROXIMO; 0 in OCIOSO and FIM.
- All outputs are registered except db_estado, which is a direct state view.

Decomposition:
- Shared package/include: state encodings (OCIOSO..FIM) and color constants (COR_VERMELHO=100, COR_VERDE=010, COR_AZUL=001, COR_AMARELO=110, COR_INVALIDA=111). Both are reused by the game's LED-feedback logic.
- One natural sub-module: decodificador_cor (combinational 4-bit one-hot to 3-bit RGB). The FSM and timer stay in this module.

Test Plan:
All tests use TEMPO_ACESO=4 and TEMPO_APAGADO=2.
- Reset mid-ACENDE (reset=0 for 1 cycle) -> leds_rgb=000, ocupado=0, db_estado=0 immediately; no fim_sequencia pulse.
- limite=0, mem[0]=0010, pulse iniciar -> leds_rgb=010 for exactly 4 cycles, then 000 for 2 cycles; fim_sequencia pulses 9 cycles after the iniciar edge; mem_endereco stays 0.
- limite=3, mem={0001,0010,0100,1000} -> leds_rgb sequence 100,010,001,110, each lit 4 cycles with gaps of ≥2 dark cycles; mem_endereco steps 0,1,2,3; fim_sequencia after 33 cycles.
- mem[0]=0000 and mem[1]=0011 with limite=1 -> leds_rgb=111 for both elements.
- limite=15, all entries 0100 -> 16 blue flashes, mem_endereco reaches 15 then returns to 0 in FIM (no wrap-around replay); iniciar pulses mid-run are ignored.
- Change limite from 2 to 0 during the first ACENDE -> three elements are still shown; a held-high iniciar restarts on the cycle after FIM.

Source files
------------

// File: rtl/exibidor_sequencia_pkg.sv
// Shared state encodings and RGB color constants
// for the sequence playback and LED feedback logic.
package exibidor_sequencia_pkg;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACENDE  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  localparam logic [2:0] COR_VERMELHO = 3'b100;
  localparam logic [2:0] COR_VERDE    = 3'b010;
  localparam logic [2:0] COR_AZUL     = 3'b001;
  localparam logic [2:0] COR_AMARELO  = 3'b110;
  localparam logic [2:0] COR_INVALIDA = 3'b111;

endpackage

// File: rtl/exibidor_sequencia_if.sv
// Bundle between the playback engine, the control
// unit and the sequence memory.
interface exibidor_sequencia_if #(
  parameter int ADDR_W = 4
);
  logic              iniciar;
  logic [ADDR_W-1:0] limite;
  logic [3:0]        mem_dado;
  logic [ADDR_W-1:0] mem_endereco;
  logic [2:0]        leds_rgb;
  logic              ocupado;
  logic              fim_sequencia;
  logic [3:0]        db_estado;

  modport master (
    output iniciar, limite, mem_dado,
    input  mem_endereco, leds_rgb,
    input  ocupado, fim_sequencia, db_estado
  );

  modport slave (
    input  iniciar, limite, mem_dado,
    output mem_endereco, leds_rgb,
    output ocupado, fim_sequencia, db_estado
  );
endinterface

// File: rtl/exibidor_sequencia_decodificador_cor.sv
// One-hot color code to RGB drive; anything that is
// not exactly one-hot lights all three channels.
module decodificador_cor
  import exibidor_sequencia_pkg::*;
(
  input  logic [3:0] codigo,
  output logic [2:0] rgb
);
  always_comb begin
    rgb = COR_INVALIDA;
    unique case (1'b1)
      (codigo == 4'b0001): rgb = COR_VERMELHO;
      (codigo == 4'b0010): rgb = COR_VERDE;
      (codigo == 4'b0100): rgb = COR_AZUL;
      (codigo == 4'b1000): rgb = COR_AMARELO;
      default:             rgb = COR_INVALIDA;
    endcase
  end
endmodule

// File: rtl/exibidor_sequencia.sv
// Playback engine: walks memory 0..limite, lighting
// each color for a fixed time followed by a dark gap.
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int TEMPO_ACESO   = 2000,
  parameter int TEMPO_APAGADO = 500,
  parameter int ADDR_W        = 4,
  parameter int CNT_W         = 12
) (
  input logic clock,
  input logic reset,
  exibidor_sequencia_if.slave bus
);
  localparam logic [CNT_W-1:0] ULT_ACESO =
    CNT_W'(TEMPO_ACESO - 1);
  localparam logic [CNT_W-1:0] ULT_APAGADO =
    CNT_W'(TEMPO_APAGADO - 1);

  estado_t           estado, estado_n;
  logic [ADDR_W-1:0] endereco, endereco_n;
  logic [ADDR_W-1:0] lim, lim_n;
  logic [CNT_W-1:0]  timer, timer_n;
  logic [2:0]        leds, leds_n;
  logic              ocupado, ocupado_n;
  logic              fim, fim_n;
  logic [2:0]        cor;

  decodificador_cor u_dec (
    .codigo (bus.mem_dado),
    .rgb    (cor)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      endereco <= '0;
      lim      <= '0;
      timer    <= '0;
      leds     <= '0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else begin
      estado   <= estado_n;
      endereco <= endereco_n;
      lim      <= lim_n;
      timer    <= timer_n;
      leds     <= leds_n;
      ocupado  <= ocupado_n;
      fim      <= fim_n;
    end
  end

  always_comb begin
    estado_n   = estado;
    endereco_n = endereco;
    lim_n      = lim;
    timer_n    = timer;
    leds_n     = leds;
    fim_n      = 1'b0;
    unique case (estado)
      OCIOSO: begin
        leds_n = '0;
        if (bus.iniciar) begin
          lim_n      = bus.limite;
          endereco_n = '0;
          estado_n   = CARREGA;
        end
      end
      CARREGA: begin
        leds_n   = cor;
        timer_n  = '0;
        estado_n = ACENDE;
      end
      ACENDE: begin
        if (timer == ULT_ACESO) begin
          leds_n   = '0;
          timer_n  = '0;
          estado_n = APAGA;
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      APAGA: begin
        leds_n = '0;
        if (timer == ULT_APAGADO) begin
          timer_n  = '0;
          estado_n = PROXIMO;
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      // compare before increment so limite=max never wraps
      PROXIMO: begin
        if (endereco == lim) begin
          estado_n = FIM;
        end else begin
          endereco_n = endereco + ADDR_W'(1);
          estado_n   = CARREGA;
        end
      end
      FIM: begin
        fim_n      = 1'b1;
        endereco_n = '0;
        estado_n   = OCIOSO;
      end
      default: begin
        leds_n     = '0;
        timer_n    = '0;
        endereco_n = '0;
        estado_n   = OCIOSO;
      end
    endcase
    ocupado_n = (estado_n == CARREGA) ||
                (estado_n == ACENDE)  ||
                (estado_n == APAGA)   ||
                (estado_n == PROXIMO);
  end

  assign bus.mem_endereco  = endereco;
  assign bus.leds_rgb      = leds;
  assign bus.ocupado       = ocupado;
  assign bus.fim_sequencia = fim;
  assign bus.db_estado     = estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for the sequence playback engine
// with short lit/dark times.
module tb_exibidor_sequencia;

  localparam int TA = 4;
  localparam int TB = 2;
  localparam int AW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  exibidor_sequencia_if #(.ADDR_W(AW)) bus ();

  logic [3:0] mem [16];
  assign bus.mem_dado = mem[bus.mem_endereco];

  exibidor_sequencia #(
    .TEMPO_ACESO   (TA),
    .TEMPO_APAGADO (TB),
    .ADDR_W        (AW),
    .CNT_W         (12)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]        lim_a;
    logic [3:0]        lim_b;
    logic [15:0][3:0]  img;
    int                n_el;
    logic [15:0][2:0]  cores;
    int                ciclos;
    bit                segura;
    bit                pulso_meio;
  } vec_t;

  vec_t v [5];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic [3:0]  a,
    input logic [3:0]  b,
    input logic [63:0] img,
    input int          n,
    input logic [47:0] cores,
    input int          cyc,
    input bit          s,
    input bit          p
  );
    vec_t r;
    r.lim_a = a;
    r.lim_b = b;
    r.img = img;
    r.n_el = n;
    r.cores = cores;
    r.ciclos = cyc;
    r.segura = s;
    r.pulso_meio = p;
    return r;
  endfunction

  task automatic chk(input string nome, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nome, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int k);
    int n, m, idx, lit, dark;
    bit done;
    logic [2:0] prev;
    int glen [32];
    int gaddr [32];
    int ggap [32];
    logic [2:0] gcor [32];
    for (int i = 0; i < 16; i++) mem[i] = v[k].img[i];
    bus.limite = v[k].lim_a;
    bus.iniciar = 1'b1;
    n = -1; idx = 0; lit = 0; dark = 0;
    done = 1'b0; prev = 3'b000;
    while (!done && n < 400) begin
      tick();
      n++;
      if (n == 0) begin
        chk("ocupado_inicio", int'(bus.ocupado), 1);
        if (!v[k].segura) bus.iniciar = 1'b0;
      end
      if (n == 2) bus.limite = v[k].lim_b;
      if (v[k].pulso_meio) bus.iniciar = (n == 50);
      if (bus.leds_rgb != 3'b000) begin
        if (prev == 3'b000) begin
          if (idx < 32) begin
            gcor[idx] = bus.leds_rgb;
            gaddr[idx] = int'(bus.mem_endereco);
            ggap[idx] = dark;
          end
          lit = 0;
        end
        lit++;
      end else begin
        if (prev != 3'b000) begin
          if (idx < 32) glen[idx] = lit;
          idx++;
          dark = 0;
        end
        dark++;
      end
      prev = bus.leds_rgb;
      if (bus.fim_sequencia) done = 1'b1;
    end
    chk("fim_visto", int'(done), 1);
    chk("ciclos_ate_fim", n, v[k].ciclos);
    chk("num_elementos", idx, v[k].n_el);
    for (int i = 0; i < v[k].n_el && i < idx; i++) begin
      chk("cor", int'(gcor[i]), int'(v[k].cores[i]));
      chk("tempo_aceso", glen[i], TA);
      chk("endereco", gaddr[i], i);
      if (i > 0) chk("gap_min", int'(ggap[i] >= TB), 1);
    end
    chk("ocupado_fim", int'(bus.ocupado), 0);
    chk("endereco_fim", int'(bus.mem_endereco), 0);
    tick();
    if (v[k].segura) begin
      chk("reinicio_estado", int'(bus.db_estado), 1);
      chk("reinicio_ocupado", int'(bus.ocupado), 1);
      chk("fim_pulso", int'(bus.fim_sequencia), 0);
      bus.iniciar = 1'b0;
      m = 0;
      done = 1'b0;
      while (!done && m < 100) begin
        tick();
        m++;
        if (bus.fim_sequencia) done = 1'b1;
      end
      chk("reinicio_ciclos", m, 9);
      tick();
    end else begin
      chk("fim_pulso", int'(bus.fim_sequencia), 0);
      chk("estado_ocioso", int'(bus.db_estado), 0);
    end
  endtask

  initial begin
    int fim_visto;
    v[0] = mk(4'd0, 4'd0, 64'h2, 1, 48'h2, 9, 0, 0);
    v[1] = mk(4'd3, 4'd3, 64'({4'b1000, 4'b0100,
              4'b0010, 4'b0001}), 4,
              48'({3'b110, 3'b001, 3'b010, 3'b100}),
              33, 0, 0);
    v[2] = mk(4'd1, 4'd1, 64'({4'b0011, 4'b0000}), 2,
              48'({3'b111, 3'b111}), 17, 0, 0);
    v[3] = mk(4'd15, 4'd15, {16{4'b0100}}, 16,
              {16{3'b001}}, 129, 0, 1);
    v[4] = mk(4'd2, 4'd0, 64'({4'b0010, 4'b0001,
              4'b1000}), 3,
              48'({3'b010, 3'b100, 3'b110}), 25, 1, 0);

    for (int i = 0; i < 16; i++) mem[i] = 4'b0000;
    reset = 1'b0;
    bus.iniciar = 1'b0;
    bus.limite = '0;
    tick();
    tick();
    chk("rst_leds", int'(bus.leds_rgb), 0);
    chk("rst_ocupado", int'(bus.ocupado), 0);
    chk("rst_fim", int'(bus.fim_sequencia), 0);
    chk("rst_endereco", int'(bus.mem_endereco), 0);
    chk("rst_estado", int'(bus.db_estado), 0);
    reset = 1'b1;
    tick();

    // asynchronous reset in the middle of ACENDE
    mem[0] = 4'b0010;
    bus.limite = 4'd0;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick();
    tick();
    chk("pre_rst_leds", int'(bus.leds_rgb), 2);
    chk("pre_rst_estado", int'(bus.db_estado), 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_leds", int'(bus.leds_rgb), 0);
    chk("arst_ocupado", int'(bus.ocupado), 0);
    chk("arst_estado", int'(bus.db_estado), 0);
    tick();
    reset = 1'b1;
    fim_visto = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.fim_sequencia) fim_visto++;
    end
    chk("arst_sem_fim", fim_visto, 0);
    chk("arst_ocioso", int'(bus.db_estado), 0);

    for (int k = 0; k < 5; k++) run(k);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
